instr_fetch_unit: RTL and testbench

//  IF stage of the pipelined MIPS core; drives instruct_memory. Owns the PC and sends the

---
 rtl/mips_pkg.sv | 6 +
 rtl/pc_reg.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 82 ++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: the NOP encoding and the default address width.
// instr_fetch_unit and instruct_memory both import this package.
package mips_pkg;
    localparam int          MIPS_ADDR_W = 32;
    localparam logic [31:0] MIPS_NOP    = 32'h0000_0000;
endpackage

// File: rtl/pc_reg.sv
// Program counter with its next-PC mux (redirect > fault > stall > advance).
// Also compares the PC against the instruction memory depth.
module pc_reg
    import mips_pkg::*;
#(
    parameter int                ADDR_W     = MIPS_ADDR_W,
    parameter int                IMEM_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc,
    output logic              out_of_range
);
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(IMEM_DEPTH);

    logic [ADDR_W-1:0] pc_next;

    assign out_of_range = (pc >= DEPTH);

    // An out-of-range PC freezes until a redirect; wrap is plain modular arithmetic.
    always_comb begin
        pc_next = pc + ADDR_W'(1);
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (out_of_range) begin
            pc_next = pc;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, drives instruct_memory (combinational read) and
// captures the returned word into the IF/ID register with stall/flush/redirect.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W     = MIPS_ADDR_W,
    parameter int                IMEM_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic [31:0]       ifid_instr,
    output logic              ifid_valid,
    output logic              fetch_fault
);
    logic [ADDR_W-1:0] pc;
    logic              out_of_range;

    pc_reg #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .out_of_range    (out_of_range)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            fetch_fault <= 1'b0;
        end else if (out_of_range) begin
            fetch_fault <= 1'b1;
        end
    end

    // Bubbles keep the PC of the dropped slot in ifid_pc for debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_instr    <= MIPS_NOP;
            ifid_valid    <= 1'b0;
        end else if (redirect_valid || out_of_range) begin
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc + ADDR_W'(1);
            ifid_instr    <= MIPS_NOP;
            ifid_valid    <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                ifid_instr <= MIPS_NOP;
                ifid_valid <= 1'b0;
            end
        end else if (flush) begin
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc + ADDR_W'(1);
            ifid_instr    <= MIPS_NOP;
            ifid_valid    <= 1'b0;
        end else begin
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc + ADDR_W'(1);
            ifid_instr    <= imem_instr;
            ifid_valid    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal pins, then random
// stall/flush/redirect/reset traffic checked every cycle against a behavioural model.
module tb_instr_fetch_unit;
    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int EXP_W = AW + 1 + 1 + 32 + AW + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic [AW-1:0] ifid_pc;
    logic [AW-1:0] ifid_pc_plus1;
    logic [31:0]   ifid_instr;
    logic          ifid_valid;
    logic          fetch_fault;

    logic [31:0]   mem [0:DEPTH-1];
    int            n_cmp  = 0;
    int            n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(AW), .IMEM_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus1   (ifid_pc_plus1),
        .ifid_instr      (ifid_instr),
        .ifid_valid      (ifid_valid),
        .fetch_fault     (fetch_fault)
    );

    // Instruction memory: combinational read, junk outside the valid range.
    assign imem_instr = (imem_addr < AW'(DEPTH)) ? mem[imem_addr[2:0]] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_pc, m_ifpc, m_ifp1;
    logic [31:0]   m_instr;
    logic          m_valid, m_fault;
    logic          started = 1'b0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic m_bubble();
        m_ifpc  = m_pc;
        m_ifp1  = m_pc + 1;
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            m_pc = '0; m_ifpc = '0; m_ifp1 = '0;
            m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (started) begin
            if (redirect_valid) begin
                m_bubble();
                m_pc    = redirect_target;
                m_fault = 1'b0;
            end else if (m_pc >= DEPTH) begin
                m_bubble();
                m_fault = 1'b1;
            end else if (stall) begin
                if (flush) begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end
            end else begin
                if (flush) begin
                    m_bubble();
                end else begin
                    m_ifpc  = m_pc;
                    m_ifp1  = m_pc + 1;
                    m_instr = mem[m_pc];
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 1;
            end
        end
        if (started) exp_q.push_back({m_pc, m_fault, m_valid, m_instr, m_ifpc, m_ifp1});
    end

    // ---------------- scoreboard: compare on the falling edge ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("imem_addr",   imem_addr,          e[EXP_W-1 -: AW]);
            check("fetch_fault", AW'(fetch_fault),   AW'(e[EXP_W-AW-1]));
            check("ifid_valid",  AW'(ifid_valid),    AW'(e[EXP_W-AW-2]));
            check("ifid_instr",  ifid_instr,         e[2*AW+31 -: 32]);
            // Bubble PC fields are debug-only, so they are compared on real instructions.
            if (e[EXP_W-AW-2]) begin
                check("ifid_pc",       ifid_pc,       e[2*AW-1 -: AW]);
                check("ifid_pc_plus1", ifid_pc_plus1, e[AW-1:0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic st, input logic fl,
                         input logic rv, input logic [AW-1:0] rt);
        rst = r; stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 + i;

        // reset state
        cycle(1, 0, 0, 0, '0);
        check("rst_pc", imem_addr, 0);
        check("rst_valid", AW'(ifid_valid), 0);
        check("rst_instr", ifid_instr, 0);

        // free run, then stall two cycles at pc=2
        run(1);
        check("run1_instr", ifid_instr, 32'hC0DE_0000);
        check("run1_valid", AW'(ifid_valid), 1);
        run(1);
        cycle(0, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        check("stall_pc", imem_addr, 2);
        check("stall_ifpc", ifid_pc, 1);
        check("stall_instr", ifid_instr, 32'hC0DE_0001);
        run(1);
        check("release_pc", imem_addr, 3);
        check("release_instr", ifid_instr, 32'hC0DE_0002);
        run(1);
        check("run_pc4", imem_addr, 4);

        // redirect back to 1
        cycle(0, 0, 0, 1, 1);
        check("redir_pc", imem_addr, 1);
        check("redir_valid", AW'(ifid_valid), 0);
        run(1);
        check("redir_ifpc", ifid_pc, 1);
        check("redir_instr", ifid_instr, 32'hC0DE_0001);

        // out-of-range target, fault, recovery
        cycle(0, 0, 0, 1, 9);
        run(1);
        check("fault_set", AW'(fetch_fault), 1);
        check("fault_pc", imem_addr, 9);
        run(1);
        check("fault_hold_valid", AW'(ifid_valid), 0);
        cycle(0, 0, 0, 1, 2);
        check("fault_clear", AW'(fetch_fault), 0);
        run(1);
        check("recover_instr", ifid_instr, 32'hC0DE_0002);

        // stall+flush+redirect together, then stall+flush
        cycle(0, 1, 1, 1, 5);
        check("sfr_pc", imem_addr, 5);
        check("sfr_valid", AW'(ifid_valid), 0);
        cycle(0, 1, 1, 0, '0);
        check("sf_pc", imem_addr, 5);
        check("sf_valid", AW'(ifid_valid), 0);
        run(1);
        check("sf_resume", ifid_instr, 32'hC0DE_0005);

        // reset while faulted
        cycle(0, 0, 0, 1, 9);
        run(1);
        cycle(1, 0, 0, 0, '0);
        check("rst2_pc", imem_addr, 0);
        check("rst2_fault", AW'(fetch_fault), 0);
        check("rst2_instr", ifid_instr, 0);
        run(1);
        check("rst2_resume", ifid_instr, 32'hC0DE_0000);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0,
                  AW'($urandom_range(0, 10)));
        end
        run(2);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
